// File: rtl/sdram_bus_arbiter.sv
// Two-requester arbiter in front of the SDRAM controller bus: fixed video priority with a
// host starvation cap, one outstanding access at a time, per-access timeout.
module sdram_bus_arbiter #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int VID_BURST_MAX  = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic                  vid_valid,
    output logic                  vid_err,
    input  logic                  host_req,
    input  logic                  host_n_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_done,
    output logic                  host_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_write,
    input  logic [DATA_WIDTH-1:0] mem_data_read,
    output logic                  mem_request,
    output logic                  mem_n_write_enable,
    input  logic                  mem_data_ready,
    input  logic                  mem_save_ready,
    input  logic                  mem_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RELEASE} state_t;
    typedef enum logic {OWN_VID, OWN_HOST} owner_t;

    localparam logic [7:0]  BURST_MAX  = 8'(VID_BURST_MAX);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state, state_n;
    owner_t                owner, owner_n;
    logic [7:0]            streak, streak_n;
    logic [15:0]           timer, timer_n;

    logic                  vid_ack_n, vid_valid_n, vid_err_n;
    logic                  host_ack_n, host_done_n, host_err_n;
    logic [DATA_WIDTH-1:0] vid_rdata_n, host_rdata_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_data_write_n;
    logic                  mem_request_n, mem_n_write_enable_n;

    logic                  grant_vid, grant_host, access_done;

    // Video wins unless the host has already waited through a full video streak.
    assign grant_vid   = vid_req && (!host_req || (streak < BURST_MAX));
    assign grant_host  = host_req && !grant_vid;
    assign access_done = mem_n_write_enable ? mem_data_ready : mem_save_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_n              = state;
        owner_n              = owner;
        streak_n             = streak;
        timer_n              = timer;
        vid_ack_n            = 1'b0;
        vid_valid_n          = 1'b0;
        vid_err_n            = 1'b0;
        vid_rdata_n          = vid_rdata;
        host_ack_n           = 1'b0;
        host_done_n          = 1'b0;
        host_err_n           = 1'b0;
        host_rdata_n         = host_rdata;
        mem_addr_n           = mem_addr;
        mem_data_write_n     = mem_data_write;
        mem_request_n        = mem_request;
        mem_n_write_enable_n = mem_n_write_enable;

        if (!host_req) streak_n = '0;

        unique case (state)
            ST_IDLE: begin
                if (!mem_busy && (vid_req || host_req)) begin
                    if (grant_vid) begin
                        owner_n              = OWN_VID;
                        mem_addr_n           = vid_addr;
                        mem_data_write_n     = '0;
                        mem_n_write_enable_n = 1'b1;
                        vid_ack_n            = 1'b1;
                        if (host_req) streak_n = streak + 8'd1;
                    end else begin
                        owner_n              = OWN_HOST;
                        mem_addr_n           = host_addr;
                        mem_data_write_n     = host_wdata;
                        mem_n_write_enable_n = host_n_we;
                        host_ack_n           = 1'b1;
                        streak_n             = '0;
                    end
                    mem_request_n = 1'b1;
                    timer_n       = '0;
                    state_n       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (access_done) begin
                    if (owner == OWN_VID) begin
                        vid_valid_n = 1'b1;
                        vid_rdata_n = mem_data_read;
                    end else begin
                        host_done_n = 1'b1;
                        if (mem_n_write_enable) host_rdata_n = mem_data_read;
                    end
                    mem_request_n = 1'b0;
                    state_n       = ST_RELEASE;
                end else if (timer == TIMER_LAST) begin
                    if (owner == OWN_VID) begin
                        vid_valid_n = 1'b1;
                        vid_err_n   = 1'b1;
                        vid_rdata_n = '0;
                    end else begin
                        host_done_n  = 1'b1;
                        host_err_n   = 1'b1;
                        host_rdata_n = '0;
                    end
                    mem_request_n = 1'b0;
                    state_n       = ST_RELEASE;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            ST_RELEASE: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            owner              <= OWN_VID;
            streak             <= '0;
            timer              <= '0;
            vid_ack            <= 1'b0;
            vid_valid          <= 1'b0;
            vid_err            <= 1'b0;
            vid_rdata          <= '0;
            host_ack           <= 1'b0;
            host_done          <= 1'b0;
            host_err           <= 1'b0;
            host_rdata         <= '0;
            mem_addr           <= '0;
            mem_data_write     <= '0;
            mem_request        <= 1'b0;
            mem_n_write_enable <= 1'b1;
        end else begin
            state              <= state_n;
            owner              <= owner_n;
            streak             <= streak_n;
            timer              <= timer_n;
            vid_ack            <= vid_ack_n;
            vid_valid          <= vid_valid_n;
            vid_err            <= vid_err_n;
            vid_rdata          <= vid_rdata_n;
            host_ack           <= host_ack_n;
            host_done          <= host_done_n;
            host_err           <= host_err_n;
            host_rdata         <= host_rdata_n;
            mem_addr           <= mem_addr_n;
            mem_data_write     <= mem_data_write_n;
            mem_request        <= mem_request_n;
            mem_n_write_enable <= mem_n_write_enable_n;
        end
    end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed bench for sdram_bus_arbiter: a table of single transactions against a simple
// controller model, plus sequences for busy hold-off, streak arbitration and async reset.
module tb_sdram_bus_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic          vid_valid, vid_err;
    logic          host_req = 1'b0;
    logic          host_n_we = 1'b1;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_done, host_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_write;
    logic [DW-1:0] mem_data_read = '0;
    logic          mem_request, mem_n_write_enable;
    logic          mem_data_ready = 1'b0;
    logic          mem_save_ready = 1'b0;
    logic          mem_busy = 1'b0;

    int total = 0;
    int bad   = 0;

    // controller model knobs
    int            mem_lat    = 1;
    bit            mem_silent = 1'b0;
    bit            mem_stray  = 1'b0;
    logic [DW-1:0] mem_rd_val = '0;
    int            mem_cnt    = 0;

    sdram_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VID_BURST_MAX(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .vid_valid(vid_valid), .vid_err(vid_err),
        .host_req(host_req), .host_n_we(host_n_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_done(host_done), .host_err(host_err),
        .mem_addr(mem_addr), .mem_data_write(mem_data_write), .mem_data_read(mem_data_read),
        .mem_request(mem_request), .mem_n_write_enable(mem_n_write_enable),
        .mem_data_ready(mem_data_ready), .mem_save_ready(mem_save_ready), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    // Controller answers mem_lat cycles into a request; optionally never, or with a stray
    // read-ready early in a write.
    always @(negedge clk) begin
        mem_data_ready = 1'b0;
        mem_save_ready = 1'b0;
        if (mem_request) begin
            mem_cnt++;
            if (!mem_silent && mem_cnt == mem_lat) begin
                if (mem_n_write_enable) begin
                    mem_data_ready = 1'b1;
                    mem_data_read  = mem_rd_val;
                end else begin
                    mem_save_ready = 1'b1;
                end
            end
            if (mem_stray && !mem_n_write_enable && mem_cnt == 1) mem_data_ready = 1'b1;
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit            host;
        bit            n_we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mem_val;
        int            lat;
        bit            silent;
        bit            stray;
        bit            chk_rd;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            exp_cycles;
    } vec_t;

    task automatic run_vec(input vec_t v, input string name);
        int   k;
        int   spur;
        int   hold_bad;
        bit   seen;
        logic exp_nwe;
        exp_nwe    = v.host ? v.n_we : 1'b1;
        mem_lat    = v.lat;
        mem_silent = v.silent;
        mem_stray  = v.stray;
        mem_rd_val = v.mem_val;
        @(negedge clk);
        if (v.host) begin
            host_req = 1'b1; host_n_we = v.n_we; host_addr = v.addr; host_wdata = v.wdata;
        end else begin
            vid_req = 1'b1; vid_addr = v.addr;
        end
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            seen = v.host ? host_ack : vid_ack;
        end
        vid_req  = 1'b0;
        host_req = 1'b0;
        check({name, " ack"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({name, " mem_request"}, 32'(mem_request), 32'd1);
        check({name, " mem_addr"}, 32'(mem_addr), 32'(v.addr));
        check({name, " mem_n_we"}, 32'(mem_n_write_enable), 32'(exp_nwe));
        if (!exp_nwe) check({name, " mem_wdata"}, 32'(mem_data_write), 32'(v.wdata));

        seen = 1'b0;
        k = 0;
        spur = 0;
        hold_bad = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            seen = v.host ? host_done : vid_valid;
            if (vid_ack || host_ack) spur++;
            if (v.host ? (vid_valid || vid_err) : (host_done || host_err)) spur++;
            if (!seen && (!mem_request || (v.host ? host_err : vid_err))) spur++;
            if (mem_addr !== v.addr || mem_n_write_enable !== exp_nwe) hold_bad++;
        end
        check({name, " done"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(k), 32'(v.exp_cycles));
        check({name, " err"}, 32'(v.host ? host_err : vid_err), 32'(v.exp_err));
        if (v.chk_rd) check({name, " rdata"}, 32'(v.host ? host_rdata : vid_rdata), 32'(v.exp_rdata));
        check({name, " req dropped"}, 32'(mem_request), 32'd0);
        check({name, " spurious"}, 32'(spur), 32'd0);
        check({name, " held bus"}, 32'(hold_bad), 32'd0);
        @(negedge clk);
        check({name, " pulse end"}, 32'({vid_valid, host_done, vid_err, host_err, mem_request}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   busy_bad;
        int   grants;
        int   cyc;
        int   last;
        int   quiet_bad;
        bit   seen;
        vec_t post;

        vecs[0] = '{0, 1, 24'h000123, 16'h0000, 16'hBEEF, 5, 0, 0, 1, 16'hBEEF, 0, 5};
        vecs[1] = '{1, 0, 24'h00ABCD, 16'h1234, 16'hDEAD, 3, 0, 1, 0, 16'h0000, 0, 3};
        vecs[2] = '{1, 1, 24'h000042, 16'h0000, 16'h5A5A, 1, 0, 0, 1, 16'h5A5A, 0, 1};
        vecs[3] = '{0, 1, 24'hFFFFFF, 16'h0000, 16'h0001, 2, 0, 0, 1, 16'h0001, 0, 2};
        vecs[4] = '{1, 1, 24'h000100, 16'h0000, 16'h9999, 1, 1, 0, 1, 16'h0000, 1, 16};
        vecs[5] = '{1, 1, 24'h000200, 16'h0000, 16'h7777, 4, 0, 0, 1, 16'h7777, 0, 4};
        vecs[6] = '{0, 1, 24'h000300, 16'h0000, 16'h4444, 1, 1, 0, 1, 16'h0000, 1, 16};
        vecs[7] = '{1, 0, 24'h00000F, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1};
        vecs[8] = '{0, 1, 24'h000400, 16'h0000, 16'h8001, 3, 0, 0, 1, 16'h8001, 0, 3};

        // reset values, with the controller busy and both requests already waiting
        mem_busy   = 1'b1;
        vid_req    = 1'b1;
        vid_addr   = 24'h000010;
        host_req   = 1'b1;
        host_n_we  = 1'b1;
        host_addr  = 24'h000020;
        mem_rd_val = 16'hAAAA;
        mem_lat    = 1;
        #2 reset = 1'b1;
        #2;
        check("rst vid_ack", 32'(vid_ack), 32'd0);
        check("rst vid_valid", 32'(vid_valid), 32'd0);
        check("rst vid_err", 32'(vid_err), 32'd0);
        check("rst vid_rdata", 32'(vid_rdata), 32'd0);
        check("rst host_ack", 32'(host_ack), 32'd0);
        check("rst host_done", 32'(host_done), 32'd0);
        check("rst host_err", 32'(host_err), 32'd0);
        check("rst host_rdata", 32'(host_rdata), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_wdata", 32'(mem_data_write), 32'd0);
        check("rst mem_request", 32'(mem_request), 32'd0);
        check("rst mem_n_we", 32'(mem_n_write_enable), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        busy_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (vid_ack || host_ack || mem_request) busy_bad++;
        end
        check("busy holdoff", 32'(busy_bad), 32'd0);

        // both requests held: expect 8 video grants then 1 host, twice, 3 cycles apart
        mem_busy = 1'b0;
        grants = 0;
        cyc = 0;
        last = -1;
        while (grants < 18 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (vid_ack || host_ack) begin
                check("arb one grant", 32'(vid_ack ^ host_ack), 32'd1);
                check($sformatf("arb grant %0d is host", grants), 32'(host_ack),
                      32'((grants % 9) == 8));
                if (last >= 0) check("arb turnaround", 32'(cyc - last), 32'd3);
                last = cyc;
                grants++;
            end
        end
        vid_req  = 1'b0;
        host_req = 1'b0;
        check("arb grant count", 32'(grants), 32'd18);
        repeat (6) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // asynchronous reset in the middle of an access that never completes
        mem_silent = 1'b1;
        @(negedge clk);
        vid_req  = 1'b1;
        vid_addr = 24'h000777;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = vid_ack;
        end
        vid_req = 1'b0;
        check("midrst ack", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("midrst in issue", 32'(mem_request), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst async drop", 32'(mem_request), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        quiet_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (vid_valid || host_done || mem_request) quiet_bad++;
        end
        check("midrst lost access", 32'(quiet_bad), 32'd0);
        post = '{0, 1, 24'h000321, 16'h0000, 16'hC0DE, 2, 0, 0, 1, 16'hC0DE, 0, 2};
        run_vec(post, "post-reset vid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
